input_ctrl: RTL and testbench



---
 rtl/io_pkg.sv | 22 ++
 rtl/input_ctrl_if.sv | 24 ++
 rtl/key_debouncer.sv | 52 +++++
 rtl/input_ctrl.sv | 85 ++++++++
 tb/tb_input_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the board I/O stages: FSM states, key polarity and
// debounce counter sizing.
package io_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StWaitPress,
    StDone
  } io_state_e;

  localparam logic        KEY_ACTIVE       = 1'b0;
  localparam int unsigned DEBOUNCE_DEFAULT = 500000;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEBOUNCE_CNT_W = cnt_width(DEBOUNCE_DEFAULT);

endpackage

// File: rtl/input_ctrl_if.sv
// Core-side handshake of the `in` instruction: request in, waiting flag,
// captured data and its valid pulse out.
interface input_ctrl_if;

  logic        in_req;
  logic        in;
  logic [31:0] in_data;
  logic        in_valid;

  modport master (
    output in_req,
    input  in,
    input  in_data,
    input  in_valid
  );

  modport slave (
    input  in_req,
    output in,
    output in_data,
    output in_valid
  );

endinterface

// File: rtl/key_debouncer.sv
// Synchronizes and debounces the push button; emits the debounced level and a
// one-cycle press pulse on the edge the level goes active.
module key_debouncer
  import io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_db,
  output logic press
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

  logic             key_s1_q, key_s2_q;
  logic             key_db_q;
  logic [CNT_W-1:0] cnt_q;
  logic             differ;
  logic             flip;

  always_comb begin
    differ = (key_s2_q != key_db_q);
    flip   = differ && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q <= 1'b1;
      key_s2_q <= 1'b1;
      key_db_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      key_s1_q <= key_n;
      key_s2_q <= key_s1_q;
      if (!differ) begin
        cnt_q <= '0;
      end else if (flip) begin
        cnt_q    <= '0;
        key_db_q <= ~key_db_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign key_db = key_db_q;
  // Fires in the cycle before key_db falls, so consumers act on that same edge.
  assign press  = flip && (key_db_q != KEY_ACTIVE);

endmodule

// File: rtl/input_ctrl.sv
// Serves the core's `in` instruction: flags the wait, requires a fresh button
// press, then returns the synchronized switches with a one-cycle valid.
module input_ctrl
  import io_pkg::*;
#(
  parameter int unsigned SW_W            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            key_n,
  input  logic [SW_W-1:0] sw,
  input_ctrl_if.slave     bus
);

  logic [SW_W-1:0] sw_s1_q, sw_s2_q;
  logic            key_db;
  logic            press;
  io_state_e       state_q;
  logic            in_q;
  logic            valid_q;
  logic [31:0]     data_q;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_n),
    .key_db (key_db),
    .press  (press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      in_q    <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.in_req) begin
            state_q <= StArm;
            in_q    <= 1'b1;
          end
        end
        // A button held when the request arrives must be released first.
        StArm: begin
          if (key_db != KEY_ACTIVE) state_q <= StWaitPress;
        end
        StWaitPress: begin
          if (press) begin
            data_q  <= 32'(sw_s2_q);
            state_q <= StDone;
            in_q    <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.in       = in_q;
  assign bus.in_valid = valid_q;
  assign bus.in_data  = data_q;

endmodule

// File: tb/tb_input_ctrl.sv
// Directed bench for input_ctrl with a short debounce window: transaction table
// plus hand-written bounce, held-key and mid-wait reset sequences.
module tb_input_ctrl;

  localparam int unsigned SW_W = 16;
  localparam int unsigned D    = 4;
  // key_n falls just after edge t; key_db falls on edge t+2+D and in_valid is
  // visible straight after that edge, i.e. D+2 edges after the key change.
  localparam int EXP_LAT = D + 2;

  typedef struct {
    logic [15:0] sw;
    bit          extra_req;
    logic [31:0] exp_data;
  } vec_t;

  logic            clk;
  logic            rst_n;
  logic            key_n;
  logic [SW_W-1:0] sw;

  input_ctrl_if bus ();

  input_ctrl #(
    .SW_W            (SW_W),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .sw    (sw),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  int overlap   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.in_valid) valid_cnt++;
    if (bus.in && bus.in_valid) overlap++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_req();
    bus.in_req = 1'b1;
    step();
    bus.in_req = 1'b0;
  endtask

  // Drives key_n low and counts edges until in_valid appears (99 on timeout).
  task automatic press_and_measure(output int lat);
    key_n = 1'b0;
    lat   = 99;
    for (int k = 1; k <= 50; k++) begin
      step();
      if (bus.in_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  vec_t vecs[4];

  initial begin
    int lat;
    int v0;

    vecs[0] = '{sw: 16'h002A, extra_req: 1'b0, exp_data: 32'h0000_002A};
    vecs[1] = '{sw: 16'h0005, extra_req: 1'b1, exp_data: 32'h0000_0005};
    vecs[2] = '{sw: 16'h0063, extra_req: 1'b0, exp_data: 32'h0000_0063};
    vecs[3] = '{sw: 16'hFFFF, extra_req: 1'b0, exp_data: 32'h0000_FFFF};

    // Reset with the key held and all switches up.
    rst_n      = 1'b0;
    key_n      = 1'b0;
    sw         = 16'hFFFF;
    bus.in_req = 1'b0;
    wait_cycles(4);
    check("reset_in", 32'(bus.in), 32'd0);
    check("reset_valid", 32'(bus.in_valid), 32'd0);
    check("reset_data", bus.in_data, 32'd0);
    key_n = 1'b1;
    rst_n = 1'b1;
    wait_cycles(8);

    for (int i = 0; i < 4; i++) begin
      v0 = valid_cnt;
      sw = vecs[i].sw;
      wait_cycles(3);
      pulse_req();
      check($sformatf("txn%0d_in_rise", i), 32'(bus.in), 32'd1);
      wait_cycles(2);
      if (vecs[i].extra_req) begin
        pulse_req();
        step();
      end
      press_and_measure(lat);
      check($sformatf("txn%0d_latency", i), lat, EXP_LAT);
      check($sformatf("txn%0d_data", i), bus.in_data, vecs[i].exp_data);
      check($sformatf("txn%0d_in_low", i), 32'(bus.in), 32'd0);
      step();
      check($sformatf("txn%0d_valid_single", i), 32'(bus.in_valid), 32'd0);
      key_n = 1'b1;
      wait_cycles(10);
      check($sformatf("txn%0d_valid_count", i), valid_cnt - v0, 1);
      check($sformatf("txn%0d_data_hold", i), bus.in_data, vecs[i].exp_data);
    end

    // Bounce: 3 low / 1 high five times must not register a press.
    v0 = valid_cnt;
    sw = 16'h1234;
    wait_cycles(3);
    pulse_req();
    wait_cycles(2);
    for (int r = 0; r < 5; r++) begin
      key_n = 1'b0;
      wait_cycles(3);
      key_n = 1'b1;
      step();
    end
    wait_cycles(2);
    check("bounce_no_valid", valid_cnt - v0, 0);
    check("bounce_still_waiting", 32'(bus.in), 32'd1);
    press_and_measure(lat);
    check("bounce_latency", lat, EXP_LAT);
    check("bounce_data", bus.in_data, 32'h0000_1234);
    key_n = 1'b1;
    wait_cycles(10);
    check("bounce_valid_count", valid_cnt - v0, 1);

    // Key already held when the request arrives.
    v0    = valid_cnt;
    sw    = 16'h00C3;
    key_n = 1'b0;
    wait_cycles(10);
    pulse_req();
    wait_cycles(20);
    check("held_no_valid", valid_cnt - v0, 0);
    check("held_waiting", 32'(bus.in), 32'd1);
    key_n = 1'b1;
    wait_cycles(8);
    press_and_measure(lat);
    check("held_latency", lat, EXP_LAT);
    check("held_data", bus.in_data, 32'h0000_00C3);
    key_n = 1'b1;
    wait_cycles(10);
    check("held_valid_count", valid_cnt - v0, 1);

    // Reset while waiting for the press drops the request.
    v0 = valid_cnt;
    sw = 16'h0777;
    wait_cycles(3);
    pulse_req();
    wait_cycles(3);
    key_n = 1'b0;
    wait_cycles(3);
    rst_n = 1'b0;
    #1;
    check("midrst_in_low", 32'(bus.in), 32'd0);
    check("midrst_data_clear", bus.in_data, 32'd0);
    step();
    rst_n = 1'b1;
    wait_cycles(20);
    check("midrst_no_valid", valid_cnt - v0, 0);
    check("midrst_idle", 32'(bus.in), 32'd0);
    key_n = 1'b1;
    wait_cycles(10);
    key_n = 1'b0;
    wait_cycles(15);
    check("idle_press_ignored", valid_cnt - v0, 0);
    key_n = 1'b1;
    wait_cycles(10);

    check("in_valid_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
